mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage controller between the EX/MEM pipeline register and Data_mem. Accepts one
//  load/store per handshake, checks alignment/range, drives Data_mem strobes, waits out its
//  1-cycle registered read, sign/zero-extends load data and presents it to MEM/WB.
//  Holds the pipeline (req_ready low) while an access is in flight.
// PARAMETERS
//  MEM_BYTES        256  bytes in Data_mem; legal byte addresses 0..MEM_BYTES-1
//  ALLOW_MISALIGNED 0    0: misaligned half/word -> fault; 1: pass address through unchanged
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   EX/MEM presents an access
//  req_ready    out  1   unit can accept (high only in IDLE)
//  req_write    in   1   1 = store, 0 = load
//  req_funct3   in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr     in   32  effective byte address
//  req_wdata    in   32  store data (rs2)
//  req_rd       in   5   load destination register
//  mem_addr     out  32  -> Data_mem addr
//  mem_write    out  1   -> Data_mem MemWrite
//  mem_read     out  1   -> Data_mem MemRead
//  mem_half     out  1   -> Data_mem HalfOperation
//  mem_byte     out  1   -> Data_mem ByteOperation
//  mem_wdata    out  32  -> Data_mem data_write
//  mem_rdata    in   32  <- Data_mem data_read (valid the cycle after mem_read)
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   MEM/WB accepts response
//  rsp_rdata    out  32  extended load data; 0 for stores/faults
//  rsp_rd       out  5   destination register; 0 for stores/faults
//  rsp_fault    out  2   00 none, 01 misaligned, 10 out-of-range, 11 illegal funct3
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; mem_write=mem_read=mem_half=mem_byte=0; mem_addr=0;
//    mem_wdata=0; rsp_valid=0; rsp_rdata=0; rsp_rd=0; rsp_fault=0. Reset mid-access aborts it;
//    a strobe already issued is not retracted, response is discarded.
//  - FSM: IDLE, ISSUE, CAPTURE, RESP. Request latched when req_valid&&req_ready in IDLE.
//  - IDLE->RESP (fault): funct3 not in {000,001,010,100,101} for loads / {000,001,010} for
//    stores -> 11; else addr+size-1 >= MEM_BYTES -> 10; else misaligned (half addr[0]!=0,
//    word addr[1:0]!=0) and ALLOW_MISALIGNED=0 -> 01. Priority 11>10>01. No strobe issued.
//  - IDLE->ISSUE: one cycle with mem_read or mem_write=1 (never both), mem_half=(size==half),
//    mem_byte=(size==byte), mem_addr/mem_wdata from latched request. Strobes 0 in all other states.
//  - Store: ISSUE->RESP. Load: ISSUE->CAPTURE (sample mem_rdata, extend) ->RESP.
//  - Extension: LB sign-ext bit7, LBU zero-ext [7:0], LH sign-ext bit15, LHU zero-ext [15:0],
//    LW unchanged. Little-endian byte order.
//  - RESP: rsp_valid=1 with rdata/rd/fault stable until rsp_ready; on rsp_ready -> IDLE.
//    rsp_valid low in all other states. No new request accepted in the RESP cycle.
//  - Latency request->rsp_valid: load 3 cycles, store 2, fault 1 (rsp_ready held high).
//    Throughput: one access per latency+1 cycles.
//  - Size-bounded range check uses 33-bit add; addr 0xFFFFFFFF word does not wrap to legal.
// STRUCTURE
//  - Shared package mem_access_pkg: funct3 constants (F3_B/H/W/BU/HU), state encoding,
//    fault codes (FLT_NONE/MISAL/RANGE/ILLEGAL).
//  - One combinational sub-module load_extend (funct3, raw[31:0] -> data[31:0]); FSM, request
//    latch and fault check stay in mem_access_unit. Bench instantiates real Data_mem behind it.
// TESTING
//  - LW 0x8 after SW 0x8 data 0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after accept.
//  - SB 0x10 data 0x000000F0, then LB 0x10 -> 0xFFFFFFF0; LBU 0x10 -> 0x000000F0.
//  - SH 0x20 data 0x8001, LH 0x20 -> 0xFFFF8001; LHU 0x20 -> 0x00008001.
//  - LW 0x6 (ALLOW_MISALIGNED=0) -> fault 01 after 1 cycle, no mem_read pulse; LW 0xFE -> 10;
//    load funct3=011 -> 11.
//  - rsp_ready low 4 cycles in RESP -> rsp_* stable, req_ready low, no strobes; then accept.
//  - rst asserted in CAPTURE -> next cycle all outputs at reset values, req_ready=1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access unit.
// Covers funct3 encodings, FSM state encoding, fault codes and an access-size helper.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_MISAL   = 2'b01;
  localparam logic [1:0] FLT_RANGE   = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Access width in bytes; funct3[1:0] selects byte/half/word.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    logic [2:0] n;
    case (f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of little-endian load data according to funct3.
// Sub-word data is taken from the low lanes of the raw read.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // Select the extension matching the load type.
  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   data = {24'd0, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   data = {16'd0, raw[15:0]};
      F3_W:    data = raw;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: accepts one access, checks it, strobes Data_mem,
// waits out the registered read and returns extended data with a fault code.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 256,
  parameter bit          ALLOW_MISALIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_half,
  output logic        mem_byte,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic [1:0]  rsp_fault
);

  state_t      state_r;
  state_t      next_state_s;
  logic        write_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic        accept_s;
  logic [2:0]  size_s;
  logic [32:0] last_byte_s;
  logic        legal_f3_s;
  logic        misal_s;
  logic [1:0]  fault_s;
  logic [31:0] ext_data_s;

  load_extend u_load_extend (
    .funct3 (funct3_r),
    .raw    (mem_rdata),
    .data   (ext_data_s)
  );

  assign accept_s = req_valid && req_ready;

  // Request check; 33-bit end address so a top-of-space access cannot wrap to legal.
  always_comb begin
    size_s      = access_bytes(req_funct3);
    last_byte_s = {1'b0, req_addr} + {30'd0, size_s} - 33'd1;
    if (req_write) begin
      legal_f3_s = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      legal_f3_s = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                   (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    end
    misal_s = ((size_s == 3'd2) && req_addr[0]) ||
              ((size_s == 3'd4) && (req_addr[1:0] != 2'b00));
    if (!legal_f3_s) begin
      fault_s = FLT_ILLEGAL;
    end else if (last_byte_s >= 33'(MEM_BYTES)) begin
      fault_s = FLT_RANGE;
    end else if (misal_s && !ALLOW_MISALIGNED) begin
      fault_s = FLT_MISAL;
    end else begin
      fault_s = FLT_NONE;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = (fault_s != FLT_NONE) ? ST_RESP : ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE:   next_state_s = write_r ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: next_state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // State, request latch and registered outputs; strobes live exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      write_r   <= 1'b0;
      funct3_r  <= 3'd0;
      rd_r      <= 5'd0;
      req_ready <= 1'b1;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_half  <= 1'b0;
      mem_byte  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_rd    <= 5'd0;
      rsp_fault <= FLT_NONE;
    end else begin
      state_r   <= next_state_s;
      req_ready <= (next_state_s == ST_IDLE);
      rsp_valid <= (next_state_s == ST_RESP);
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_half  <= 1'b0;
      mem_byte  <= 1'b0;
      if (accept_s) begin
        write_r  <= req_write;
        funct3_r <= req_funct3;
        rd_r     <= req_rd;
      end
      if (accept_s && (fault_s == FLT_NONE)) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        mem_write <= req_write;
        mem_read  <= !req_write;
        mem_half  <= (size_s == 3'd2);
        mem_byte  <= (size_s == 3'd1);
      end
      // Response payload is loaded on the cycle that enters RESP and then held.
      if (accept_s && (fault_s != FLT_NONE)) begin
        rsp_rdata <= 32'd0;
        rsp_rd    <= 5'd0;
        rsp_fault <= fault_s;
      end else if ((state_r == ST_ISSUE) && write_r) begin
        rsp_rdata <= 32'd0;
        rsp_rd    <= 5'd0;
        rsp_fault <= FLT_NONE;
      end else if (state_r == ST_CAPTURE) begin
        rsp_rdata <= ext_data_s;
        rsp_rd    <= rd_r;
        rsp_fault <= FLT_NONE;
      end
    end
  end

endmodule
